// File: rtl/cycle_sequencer_pkg.sv
// rtl/cycle_sequencer_pkg.sv - shared types and instruction-class decode for the Nandy sequencer
package cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_PH0 = 2'd0,
        ST_PH1 = 2'd1,
        ST_IOW = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_SIMPLE = 2'd0,
        CLS_MEM    = 2'd1,
        CLS_IO     = 2'd2
    } inst_class_t;

    localparam logic [7:0] RESET_INST = 8'h00;

    // Must stay bit-identical to the RD/WR and memory terms in control.
    function automatic inst_class_t inst_class(input logic [7:2] op);
        if (op[7]) begin
            return CLS_MEM;
        end else if ((op[6:4] == 3'b000) && (op[3] || op[2])) begin
            return CLS_IO;
        end else begin
            return CLS_SIMPLE;
        end
    endfunction

endpackage

// File: rtl/io_watchdog.sv
// rtl/io_watchdog.sv - counts I/O wait cycles and flags when the io_req budget is spent
module io_watchdog #(
    parameter int IO_TIMEOUT = 15
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW  = $clog2(IO_TIMEOUT + 1);
    localparam int CW1 = CW + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count < CW'(IO_TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // The first io_req cycle happens in PH0 before the count starts, so the
    // budget is spent when (PH0 cycle + completed waits + this cycle) reaches the limit.
    assign expired = ({1'b0, count} + CW1'(2)) >= CW1'(IO_TIMEOUT);

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - instruction register, phase bit and completion control for the Nandy core
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int         IO_TIMEOUT = 15,
    parameter logic [7:0] IRQ_INST   = 8'h10
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] inst_in,
    input  logic       hold,
    input  logic       irq,
    input  logic       sei,
    input  logic       nCLI,
    input  logic       io_ack,
    output logic [7:0] inst,
    output logic       cycle,
    output logic       ncycle,
    output logic       pc_inc,
    output logic       io_req,
    output logic       io_err,
    output logic       ie
);

    seq_state_t  state;
    inst_class_t cls;
    logic        in_io;
    logic        wd_expired;
    logic        timeout;
    logic        done_raw;
    logic        complete;
    logic        take_irq;

    assign cls   = inst_class(inst[7:2]);
    assign in_io = (state == ST_IOW) || ((state == ST_PH0) && (cls == CLS_IO));

    io_watchdog #(
        .IO_TIMEOUT(IO_TIMEOUT)
    ) u_io_watchdog (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (state != ST_IOW),
        .enable ((state == ST_IOW) && !hold),
        .expired(wd_expired)
    );

    // With a one-cycle budget the PH0 request cycle alone exhausts it.
    assign timeout = (state == ST_IOW) ? wd_expired : (IO_TIMEOUT == 1);

    always_comb begin
        done_raw = 1'b0;
        case (state)
            ST_PH0: begin
                case (cls)
                    CLS_MEM: done_raw = 1'b0;
                    CLS_IO:  done_raw = io_ack || timeout;
                    default: done_raw = 1'b1;
                endcase
            end
            ST_PH1:  done_raw = 1'b1;
            ST_IOW:  done_raw = io_ack || timeout;
            default: done_raw = 1'b0;
        endcase
        complete = done_raw && !hold;
        take_irq = complete && irq && ie;
    end

    assign pc_inc = complete && !take_irq;
    assign io_req = in_io;
    assign io_err = in_io && !hold && !io_ack && timeout;
    assign ncycle = ~cycle;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ST_PH0;
            inst  <= RESET_INST;
            cycle <= 1'b0;
            ie    <= 1'b0;
        end else if (complete) begin
            state <= ST_PH0;
            cycle <= 1'b0;
            if (take_irq) begin
                inst <= IRQ_INST;
                ie   <= 1'b0;
            end else begin
                inst <= inst_in;
                if (!nCLI) begin
                    ie <= 1'b0;
                end else if (sei) begin
                    ie <= 1'b1;
                end
            end
        end else if (!hold) begin
            case (state)
                ST_PH0: begin
                    if (cls == CLS_MEM) begin
                        state <= ST_PH1;
                        cycle <= 1'b1;
                    end else if (cls == CLS_IO) begin
                        state <= ST_IOW;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - directed bench for cycle_sequencer with an instruction-level reference model
module tb_cycle_sequencer;

    localparam int         T   = 4;
    localparam logic [7:0] IRQ = 8'h10;

    logic       clk = 1'b0;
    logic       nrst, hold, irq, sei, ncli, io_ack;
    logic [7:0] inst_in;
    logic [7:0] inst;
    logic       cycle, ncycle, pc_inc, io_req, io_err, ie;

    int checks   = 0;
    int failures = 0;

    cycle_sequencer #(.IO_TIMEOUT(T), .IRQ_INST(IRQ)) dut (
        .clk(clk), .nrst(nrst), .inst_in(inst_in), .hold(hold), .irq(irq),
        .sei(sei), .nCLI(ncli), .io_ack(io_ack), .inst(inst), .cycle(cycle),
        .ncycle(ncycle), .pc_inc(pc_inc), .io_req(io_req), .io_err(io_err), .ie(ie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current instruction plus how many un-held cycles it has been
    // executing; outputs follow from the class rules and that age.
    logic [7:0] m_inst, n_inst;
    int         m_age, n_age;
    logic       m_ie, n_ie;
    bit         m_valid = 0, n_valid = 0;
    bit         e_mem, e_io, e_done, e_err, e_take, e_ph1;

    always @(negedge clk) begin
        if (m_valid) begin
            e_mem = m_inst[7];
            e_io  = (m_inst[7:4] == 4'h0) && (m_inst[3] || m_inst[2]);
            e_ph1 = e_mem && (m_age == 1);
            if (e_io)       e_done = io_ack || (m_age + 1 >= T);
            else if (e_mem) e_done = (m_age == 1);
            else            e_done = 1'b1;
            e_err  = e_io && !hold && !io_ack && (m_age + 1 >= T);
            e_done = e_done && !hold;
            e_take = e_done && irq && m_ie;
            check("m_inst",   inst,   m_inst);
            check("m_cycle",  cycle,  8'(e_ph1));
            check("m_ncycle", ncycle, 8'(!e_ph1));
            check("m_pc_inc", pc_inc, 8'(e_done && !e_take));
            check("m_io_req", io_req, 8'(e_io));
            check("m_io_err", io_err, 8'(e_err));
            check("m_ie",     ie,     8'(m_ie));
        end
        n_inst = m_inst; n_age = m_age; n_ie = m_ie;
        n_valid = m_valid || !nrst;
        if (!nrst) begin
            n_inst = 8'h00; n_age = 0; n_ie = 1'b0;
        end else if (m_valid && e_done) begin
            n_age  = 0;
            n_inst = e_take ? IRQ : inst_in;
            if (e_take)     n_ie = 1'b0;
            else if (!ncli) n_ie = 1'b0;
            else if (sei)   n_ie = 1'b1;
        end else if (!hold) begin
            n_age = m_age + 1;
        end
    end

    always @(posedge clk) begin
        m_valid = n_valid; m_inst = n_inst; m_age = n_age; m_ie = n_ie;
    end

    task automatic d(input logic r, input logic [7:0] ii, input logic h, input logic q,
                     input logic s, input logic nc, input logic a);
        @(posedge clk);
        #1;
        nrst = r; inst_in = ii; hold = h; irq = q; sei = s; ncli = nc; io_ack = a;
        #3;
    endtask

    initial begin
        nrst = 1'b0; inst_in = 8'h40; hold = 1'b0; irq = 1'b0;
        sei = 1'b0; ncli = 1'b1; io_ack = 1'b0;

        d(0, 8'h40, 0, 0, 0, 1, 0);
        check("rst_inst", inst, 8'h00);   check("rst_pc_inc", pc_inc, 1);
        check("rst_io_req", io_req, 0);   check("rst_io_err", io_err, 0);
        check("rst_ie", ie, 0);           check("rst_cycle", cycle, 0);
        check("rst_ncycle", ncycle, 1);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("first_pc_inc", pc_inc, 1);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("simple_inst", inst, 8'h40); check("simple_pc_inc", pc_inc, 1);
        check("simple_cycle", cycle, 0);

        // MEM: two phases, ack in PH1 ignored
        d(1, 8'h80, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("mem_ph0_cycle", cycle, 0); check("mem_ph0_pc_inc", pc_inc, 0);
        d(1, 8'h40, 0, 0, 0, 1, 1);
        check("mem_ph1_cycle", cycle, 1); check("mem_ph1_pc_inc", pc_inc, 1);
        check("mem_ack_ignored", io_req, 0);
        d(1, 8'h04, 0, 0, 0, 1, 0);
        check("mem_done_inst", inst, 8'h40); check("mem_done_cycle", cycle, 0);

        // RD acked in 4th request cycle (coincides with budget: ack wins)
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("rd_c1_io_req", io_req, 1); check("rd_c1_pc_inc", pc_inc, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("rd_c3_io_req", io_req, 1); check("rd_c3_pc_inc", pc_inc, 0);
        d(1, 8'h40, 0, 0, 0, 1, 1);
        check("rd_ack_pc_inc", pc_inc, 1); check("rd_ack_io_err", io_err, 0);
        d(1, 8'h04, 0, 0, 0, 1, 0);
        check("rd_after_io_req", io_req, 0);

        // RD never acked: watchdog fires in 4th cycle
        d(1, 8'h40, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("to_c3_io_err", io_err, 0);
        d(1, 8'h08, 0, 0, 0, 1, 0);
        check("to_c4_io_err", io_err, 1); check("to_c4_pc_inc", pc_inc, 1);
        check("to_c4_io_req", io_req, 1);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("to_next_inst", inst, 8'h08); check("to_next_io_err", io_err, 0);

        // WR acked early
        d(1, 8'h40, 0, 0, 0, 1, 1);
        check("wr_ack_pc_inc", pc_inc, 1); check("wr_ack_io_err", io_err, 0);

        // interrupts
        d(1, 8'h40, 0, 1, 1, 1, 0);
        check("irq_masked_pc_inc", pc_inc, 1); check("irq_masked_ie", ie, 0);
        d(1, 8'h40, 0, 1, 0, 1, 0);
        check("irq_take_ie", ie, 1); check("irq_take_pc_inc", pc_inc, 0);
        d(1, 8'h40, 0, 1, 0, 1, 0);
        check("irq_inst", inst, IRQ); check("irq_ie_clr", ie, 0);
        check("irq_after_pc_inc", pc_inc, 1);
        d(1, 8'h40, 0, 0, 1, 0, 0);
        d(1, 8'h40, 0, 0, 1, 1, 0);
        check("cli_wins_ie", ie, 0);

        // hold during IOW, then reset mid-IOW
        d(1, 8'h0C, 1, 0, 0, 1, 0);
        check("hold_ie", ie, 1); check("hold_pc_inc", pc_inc, 0);
        check("hold_inst", inst, 8'h40);
        d(1, 8'h0C, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("iow_entry_io_req", io_req, 1);
        d(1, 8'h40, 1, 0, 0, 1, 1);
        check("held_ack_pc_inc", pc_inc, 0); check("held_ack_io_req", io_req, 1);
        for (int i = 0; i < 5; i++) d(1, 8'h40, 1, 0, 0, 1, 0);
        check("held_no_io_err", io_err, 0); check("held_inst", inst, 8'h0C);
        d(0, 8'h40, 1, 0, 0, 1, 0);
        check("rst_cycle_io_req", io_req, 1);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("iow_rst_inst", inst, 8'h00); check("iow_rst_io_req", io_req, 0);
        check("iow_rst_ie", ie, 0);

        // reset mid-PH1
        d(1, 8'h80, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        d(0, 8'h40, 0, 0, 0, 1, 0);
        check("ph1_before_rst", cycle, 1);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        check("ph1_rst_cycle", cycle, 0); check("ph1_rst_inst", inst, 8'h00);
        d(1, 8'h40, 0, 0, 0, 1, 0);
        d(1, 8'h40, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
